seg7_letter_decoder: RTL and testbench

- Inverse of the team's letter-to-7-segment display driver. Accepts GFEDCBA segment patterns over a valid/ready handshake and decodes each one back to a 5-bit letter index (a=0 .. z=25).
- Flags patterns that are not letters and buffers decoded results in a small output FIFO.
- Sits between a segment-pattern source (capture logic or a test stream) and letter-consuming logic.

---
 rtl/seg7_letter_decoder.sv | 139 +++++++++++++
 tb/tb_seg7_letter_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_letter_decoder.sv
// GFEDCBA segment pattern -> letter index decoder with output FIFO; 1-cycle latency when empty,
// in_ready drops only on a full FIFO (no full bypass). Optional error counter under SEG7_ERRCNT_EN.
module seg7_letter_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4:0]       letter,
    output logic             err,
    output logic             blank,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] letter_cnt
`ifdef SEG7_ERRCNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0] letter;
        logic       err;
        logic       blank;
    } entry_t;

    entry_t          dec;
    entry_t          mem_q [DEPTH];
    entry_t          head;
    entry_t          last_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [CNT_W-1:0] letter_cnt_q, letter_cnt_d;
    logic            push, pop;

    always_comb begin
        dec = '{letter: 5'h1F, err: 1'b0, blank: 1'b0};
        case (seg_in)
            7'h77: dec.letter = 5'd0;
            7'h7C: dec.letter = 5'd1;
            7'h58: dec.letter = 5'd2;
            7'h5E: dec.letter = 5'd3;
            7'h79: dec.letter = 5'd4;
            7'h71: dec.letter = 5'd5;
            7'h6F: dec.letter = 5'd6;
            7'h76: dec.letter = 5'd7;
            7'h06: dec.letter = 5'd8;
            7'h1E: dec.letter = 5'd9;
            7'h78: dec.letter = 5'd10;
            7'h38: dec.letter = 5'd11;
            7'h15: dec.letter = 5'd12;
            7'h54: dec.letter = 5'd13;
            7'h5C: dec.letter = 5'd14;
            7'h73: dec.letter = 5'd15;
            7'h67: dec.letter = 5'd16;
            7'h50: dec.letter = 5'd17;
            7'h6D: dec.letter = 5'd18;
            7'h46: dec.letter = 5'd19;
            7'h3E: dec.letter = 5'd20;
            7'h1C: dec.letter = 5'd21;
            7'h2A: dec.letter = 5'd22;
            7'h49: dec.letter = 5'd23;
            7'h6E: dec.letter = 5'd24;
            7'h5B: dec.letter = 5'd25;
            7'h40: dec.blank  = 1'b1;
            default: dec.err  = 1'b1;
        endcase
    end

    assign in_ready  = (count_q < (AW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Outputs freeze on the last shown head once the FIFO drains.
    assign head   = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign letter = head.letter;
    assign err    = head.err;
    assign blank  = head.blank;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        letter_cnt_d = letter_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (push && !dec.err && !dec.blank && (letter_cnt_q != '1))
            letter_cnt_d = letter_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            letter_cnt_q <= '0;
            last_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            letter_cnt_q <= letter_cnt_d;
            last_q       <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign letter_cnt = letter_cnt_q;

`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || err_clr)
            err_cnt_q <= '0;
        else if (push && dec.err && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_letter_decoder.sv
// Directed bench for seg7_letter_decoder (DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_seg7_letter_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       seg_in;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       letter;
    logic             err;
    logic             blank;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] letter_cnt;
`ifdef SEG7_ERRCNT_EN
    logic             err_clr;
    logic [7:0]       err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    seg7_letter_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .letter     (letter),
        .err        (err),
        .blank      (blank),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .letter_cnt (letter_cnt)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_clr    (err_clr),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seg_in = 7'h00;
`ifdef SEG7_ERRCNT_EN
        err_clr = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        checks++;
        if (letter !== 5'd0 || err !== 1'b0 || blank !== 1'b0 || letter_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_vals letter=%h err=%b blank=%b cnt=%h expected 0 0 0 0",
                     letter, err, blank, letter_cnt);
        end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_errcnt got=%h expected 00", err_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        logic [6:0] pats [3] = '{7'h77, 7'h7C, 7'h58};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seg_in = pats[i]; in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || letter !== 5'(i) || err !== 1'b0 || blank !== 1'b0) begin
                failures++;
                $display("FAIL stream_%0d valid=%b letter=%0d err=%b blank=%b expected 1 %0d 0 0",
                         i, out_valid, letter, err, blank, i);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || letter !== 5'd2 || letter_cnt !== 4'd3) begin
            failures++;
            $display("FAIL stream_end valid=%b letter=%0d cnt=%0d expected 0 2 3",
                     out_valid, letter, letter_cnt);
        end
    endtask

    task automatic test_blank_err();
        out_ready = 1'b0;
        seg_in = 7'h40; in_valid = 1'b1; step();
        seg_in = 7'h7F; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || letter !== 5'h1F || blank !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL blank_entry valid=%b letter=%h blank=%b err=%b expected 1 1f 1 0",
                     out_valid, letter, blank, err);
        end
        out_ready = 1'b1; step();
        checks++;
        if (out_valid !== 1'b1 || letter !== 5'h1F || blank !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_entry valid=%b letter=%h blank=%b err=%b expected 1 1f 0 1",
                     out_valid, letter, blank, err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || letter_cnt !== 4'd3) begin
            failures++;
            $display("FAIL blank_err_cnt valid=%b cnt=%0d expected 0 3", out_valid, letter_cnt);
        end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL errcnt_inc got=%0d expected 1", err_cnt);
        end
        seg_in = 7'h7F; in_valid = 1'b1; err_clr = 1'b1; step();
        in_valid = 1'b0; err_clr = 1'b0; step();
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL errcnt_clr_wins got=%0d expected 0", err_cnt);
        end
`endif
    endtask

    task automatic test_full();
        out_ready = 1'b0; seg_in = 7'h5B; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_fill_%0d in_ready=%b expected 1", i, in_ready);
            end
            step();
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_hold in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
        end
        out_ready = 1'b1;
        checks++;
        if (letter !== 5'd25) begin
            failures++;
            $display("FAIL full_pop_0 letter=%0d expected 25", letter);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || letter !== 5'd25) begin
            failures++;
            $display("FAIL full_pop_1 in_ready=%b valid=%b letter=%0d expected 1 1 25",
                     in_ready, out_valid, letter);
        end
        step();
        in_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || letter !== 5'd25) begin
                failures++;
                $display("FAIL full_pop_%0d valid=%b letter=%0d expected 1 25", i, out_valid, letter);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || letter_cnt !== 4'd8) begin
            failures++;
            $display("FAIL full_drain valid=%b cnt=%0d expected 0 8", out_valid, letter_cnt);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; seg_in = 7'h77; in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || letter_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset valid=%b in_ready=%b cnt=%0d expected 0 1 0",
                     out_valid, in_ready, letter_cnt);
        end
        out_ready = 1'b1; seg_in = 7'h2A; in_valid = 1'b1; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || letter !== 5'd22) begin
            failures++;
            $display("FAIL post_reset valid=%b letter=%0d expected 1 22", out_valid, letter);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || letter_cnt !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_drain valid=%b cnt=%0d expected 0 1", out_valid, letter_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pats [12] = '{7'h06, 7'h1E, 7'h78, 7'h38, 7'h15, 7'h54,
                                  7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h46};
        out_ready = 1'b0; in_valid = 1'b1;
        seg_in = pats[0]; step();
        seg_in = pats[1]; step();
        out_ready = 1'b1;
        // Letters 8..19 must come out in order while two entries stay buffered.
        for (int k = 0; k < 10; k++) begin
            seg_in = pats[k+2];
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || letter !== 5'(8 + k)) begin
                failures++;
                $display("FAIL b2b_%0d valid=%b in_ready=%b letter=%0d expected 1 1 %0d",
                         k, out_valid, in_ready, letter, 8 + k);
            end
            step();
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            checks++;
            if (out_valid !== 1'b1 || letter !== 5'(8 + k)) begin
                failures++;
                $display("FAIL b2b_drain_%0d valid=%b letter=%0d expected 1 %0d",
                         k, out_valid, letter, 8 + k);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || letter_cnt !== 4'd13) begin
            failures++;
            $display("FAIL b2b_end valid=%b cnt=%0d expected 0 13", out_valid, letter_cnt);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1; seg_in = 7'h77; in_valid = 1'b1;
        step(); step();
        checks++;
        if (letter_cnt !== 4'hF) begin
            failures++;
            $display("FAIL sat_reach cnt=%h expected f", letter_cnt);
        end
        for (int i = 0; i < 18; i++) step();
        in_valid = 1'b0; step();
        checks++;
        if (letter_cnt !== 4'hF || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_hold cnt=%h valid=%b expected f 0", letter_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_blank_err();
        test_full();
        test_mid_reset();
        test_back_to_back();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
